periph_arb: RTL and testbench

PERIPH_ARB -- requirements
Module: periph_arb

---
 rtl/periph_arb.sv | 143 ++++++++++++++
 tb/tb_periph_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_arb.sv
// rtl/periph_arb.sv - two-master to one-peripheral arbiter with IDLE/ISSUE/RESP access sequencing
module periph_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_data_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_data_o,

  output logic        s_req_valid_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // r_last / r_id / w_win encode a master as 0 = m0, 1 = m1
  logic        r_last;
  logic        r_id;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_sel;

  logic        w_any;
  logic        w_win;
  logic        w_gnt;

  // Winner selection: a lone requester always wins; on contention either
  // m0 wins outright (fixed priority) or the master not served last wins.
  always_comb begin
    w_any = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) begin
      w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end else begin
      w_win = m1_req_i;
    end
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all handshake outputs. Grants are gated with rst_n so
  // nothing is granted while the block is held in reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt         = 1'b0;
    m0_gnt_o      = 1'b0;
    m1_gnt_o      = 1'b0;
    m0_rvalid_o   = 1'b0;
    m1_rvalid_o   = 1'b0;
    m0_data_o     = 32'd0;
    m1_data_o     = 32'd0;
    s_req_valid_o = 1'b0;
    s_we_o        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && rst_n) begin
          w_gnt       = 1'b1;
          m0_gnt_o    = ~w_win;
          m1_gnt_o    = w_win;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        s_req_valid_o = 1'b1;
        s_we_o        = r_we;
        w_state_nxt   = RESP;
      end
      RESP: begin
        m0_rvalid_o = ~r_id;
        m1_rvalid_o = r_id;
        if (!r_we) begin
          if (r_id) begin
            m1_data_o = s_data_i;
          end else begin
            m0_data_o = s_data_i;
          end
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command capture on grant; the winner's later req/field changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_sel  <= 4'd0;
    end else if (w_gnt) begin
      r_last <= w_win;
      r_id   <= w_win;
      r_we   <= w_win ? m1_we_i   : m0_we_i;
      r_addr <= w_win ? m1_addr_i : m0_addr_i;
      r_data <= w_win ? m1_data_i : m0_data_i;
      r_sel  <= w_win ? m1_sel_i  : m0_sel_i;
    end
  end

  assign s_addr_o = r_addr;
  assign s_data_o = r_data;
  assign s_sel_o  = r_sel;

endmodule

// File: tb/tb_periph_arb.sv
// tb/tb_periph_arb.sv - scoreboard testbench for periph_arb
module tb_periph_arb;

  typedef struct {
    int          cyc;
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data, s_data_i;
  logic [3:0]  m0_sel, m1_sel;

  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        s_req_valid_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;

  logic        f_m0_gnt, f_m0_rv, f_m1_gnt, f_m1_rv, f_sv, f_we;
  logic [31:0] f_m0_d, f_m1_d, f_addr, f_data;
  logic [3:0]  f_sel;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  m_busy  = 0;
  bit  m_last  = 1'b1;
  bit  in_cont = 1'b0;
  int  f_m0_cnt = 0;
  int  f_m1_cnt = 0;
  ev_t gq[$];
  ev_t sq[$];
  ev_t rq[$];
  int  gcyc[$];
  bit  gid[$];

  periph_arb #(.FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_sel_i(m0_sel),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_data_o(m0_data_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_sel_i(m1_sel),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_data_o(m1_data_o),
    .s_req_valid_o(s_req_valid_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_sel_o(s_sel_o), .s_data_i(s_data_i)
  );

  periph_arb #(.FIXED_PRIO(1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_sel_i(m0_sel),
    .m0_gnt_o(f_m0_gnt), .m0_rvalid_o(f_m0_rv), .m0_data_o(f_m0_d),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_sel_i(m1_sel),
    .m1_gnt_o(f_m1_gnt), .m1_rvalid_o(f_m1_rv), .m1_data_o(f_m1_d),
    .s_req_valid_o(f_sv), .s_we_o(f_we), .s_addr_o(f_addr), .s_data_o(f_data),
    .s_sel_o(f_sel), .s_data_i(s_data_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {56'd0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                          s_req_valid_o, s_we_o, 2'b00}, 64'd0);
    chk({name, "_mdata"}, {m0_data_o, m1_data_o}, 64'd0);
    chk({name, "_saddr_data"}, {s_addr_o, s_data_o}, 64'd0);
    chk({name, "_ssel"}, {60'd0, s_sel_o}, 64'd0);
  endtask

  // Reference model: evaluates the current cycle's inputs, queues expected events, then advances.
  task automatic tick();
    ev_t e;
    bit  w;
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1'b1;
      sq.delete();
      rq.delete();
    end else if (m_busy == 0) begin
      if (m0_req || m1_req) begin
        w      = (m0_req && m1_req) ? ~m_last : m1_req;
        e.cyc  = cyc;
        e.id   = w;
        e.we   = w ? m1_we   : m0_we;
        e.addr = w ? m1_addr : m0_addr;
        e.data = w ? m1_data : m0_data;
        e.sel  = w ? m1_sel  : m0_sel;
        gq.push_back(e);
        e.cyc = cyc + 1;
        sq.push_back(e);
        e.cyc = cyc + 2;
        rq.push_back(e);
        m_last = w;
        m_busy = 1;
      end
    end else if (m_busy == 1) begin
      m_busy = 2;
    end else begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents gnt, strobe or rvalid.
  always @(negedge clk) begin
    ev_t e;
    chk("gnt_onehot", {63'd0, m0_gnt_o & m1_gnt_o}, 64'd0);
    chk("rvalid_onehot", {63'd0, m0_rvalid_o & m1_rvalid_o}, 64'd0);
    chk("fix_gnt_onehot", {63'd0, f_m0_gnt & f_m1_gnt}, 64'd0);
    if (in_cont) begin
      if (f_m0_gnt) f_m0_cnt++;
      if (f_m1_gnt) f_m1_cnt++;
    end
    if (m0_gnt_o || m1_gnt_o) begin
      gcyc.push_back(cyc);
      gid.push_back(m1_gnt_o);
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 64'd1, 64'd0);
      end else begin
        e = gq.pop_front();
        chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
        chk("gnt_id", {63'd0, m1_gnt_o}, {63'd0, e.id});
      end
    end
    if (s_req_valid_o) begin
      if (sq.size() == 0) begin
        chk("sreq_unexpected", 64'd1, 64'd0);
      end else begin
        e = sq.pop_front();
        chk("sreq_cycle", 64'(cyc), 64'(e.cyc));
        chk("sreq_addr", {32'd0, s_addr_o}, {32'd0, e.addr});
        chk("sreq_data", {32'd0, s_data_o}, {32'd0, e.data});
        chk("sreq_we_sel", {59'd0, s_we_o, s_sel_o}, {59'd0, e.we, e.sel});
      end
    end else begin
      chk("we_outside_issue", {63'd0, s_we_o}, 64'd0);
    end
    if (m0_rvalid_o || m1_rvalid_o) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        e = rq.pop_front();
        chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        chk("rvalid_id", {63'd0, m1_rvalid_o}, {63'd0, e.id});
        chk("rvalid_data", {32'd0, m1_rvalid_o ? m1_data_o : m0_data_o},
            {32'd0, e.we ? 32'd0 : s_data_i});
        chk("rvalid_other_data", {32'd0, m1_rvalid_o ? m0_data_o : m1_data_o}, 64'd0);
      end
    end else begin
      chk("data_without_rvalid", {m0_data_o, m1_data_o}, 64'd0);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_data = 0; m0_sel = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_data = 0; m1_sel = 0;
    s_data_i = 32'd0;

    ticks(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    ticks(2);

    // single write from m0
    m0_req = 1; m0_we = 1; m0_addr = 32'h4; m0_data = 32'h0000_00A5; m0_sel = 4'hF;
    #1;
    chk("wr_gnt_N", {62'd0, m0_gnt_o, m1_gnt_o}, 64'd2);
    tick();
    m0_req = 0;
    chk("wr_issue_N1", {62'd0, s_req_valid_o, s_we_o}, 64'd3);
    chk("wr_addr_data_N1", {s_addr_o, s_data_o}, {32'h4, 32'hA5});
    tick();
    chk("wr_rvalid_N2", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd2);
    chk("wr_data_N2", {32'd0, m0_data_o}, 64'd0);
    ticks(2);

    // single read from m1
    s_data_i = 32'h0000_0009;
    m1_req = 1; m1_we = 0; m1_addr = 32'h0; m1_sel = 4'hF; m1_data = 32'hDEAD_BEEF;
    tick();
    m1_req = 0;
    tick();
    chk("rd_rvalid_N2", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd1);
    chk("rd_data_N2", {32'd0, m1_data_o}, 64'h9);
    ticks(2);

    // contention, both held: round-robin on u_dut, m0 only on u_fix
    gcyc.delete(); gid.delete();
    in_cont = 1'b1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_data = 32'h1111_0000; m0_sel = 4'h3;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_data = 32'h2222_0000; m1_sel = 4'hC;
    s_data_i = 32'h0BAD_F00D;
    ticks(12);
    m0_req = 0; m1_req = 0;
    ticks(3);
    in_cont = 1'b0;
    n = gid.size();
    chk("rr_grant_count", 64'(n), 64'd4);
    if (n == 4) begin
      chk("rr_order", {60'd0, gid[0], gid[1], gid[2], gid[3]}, {60'd0, 4'b0101});
      chk("rr_spacing", {gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]}, {32'd3, 32'd3});
      chk("rr_spacing_last", 64'(gcyc[3] - gcyc[2]), 64'd3);
    end
    chk("fix_m0_grants", 64'(f_m0_cnt), 64'd4);
    chk("fix_m1_starved", 64'(f_m1_cnt), 64'd0);

    // late arrival: m1 raises req during m0's ISSUE
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    tick();
    m0_req = 0; m1_req = 1; m1_we = 1; m1_addr = 32'h34; m1_data = 32'h5A5A_5A5A;
    #1;
    chk("late_no_gnt_issue", {62'd0, m0_gnt_o, m1_gnt_o}, 64'd0);
    tick();
    chk("late_no_gnt_resp", {62'd0, m0_gnt_o, m1_gnt_o}, 64'd0);
    tick();
    chk("late_gnt_N3", {62'd0, m0_gnt_o, m1_gnt_o}, 64'd1);
    tick();
    m1_req = 0;
    ticks(3);

    // withdrawal: m0 pulses req for one cycle during m1's RESP
    gcyc.delete(); gid.delete();
    m1_req = 1; m1_we = 0; m1_addr = 32'h40;
    s_data_i = 32'h1234_5678;
    tick();
    m1_req = 0;
    tick();
    m0_req = 1; m0_we = 1; m0_addr = 32'h44;
    tick();
    m0_req = 0;
    ticks(4);
    chk("withdraw_grants", 64'(gid.size()), 64'd1);

    // reset during RESP of an m1 read
    m1_req = 1; m1_we = 0; m1_addr = 32'h50; m1_sel = 4'h1;
    s_data_i = 32'h0000_0077;
    tick();
    m1_req = 0;
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_in_resp");
    ticks(2);
    rst_n = 1'b1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h8; m1_sel = 4'hF;
    #1;
    chk("post_reset_gnt", {62'd0, m0_gnt_o, m1_gnt_o}, 64'd1);
    tick();
    m1_req = 0;
    ticks(4);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      m0_req  = ($urandom_range(0, 3) != 0);
      m1_req  = ($urandom_range(0, 3) != 0);
      m0_we   = 1'($urandom);
      m1_we   = 1'($urandom);
      m0_addr = $urandom; m0_data = $urandom; m0_sel = 4'($urandom);
      m1_addr = $urandom; m1_data = $urandom; m1_sel = 4'($urandom);
      s_data_i = $urandom;
      tick();
    end
    m0_req = 0; m1_req = 0;
    ticks(5);

    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("sq_drained", 64'(sq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
